// File: rtl/int2fp_seq.sv
// ---------------------------------------------------------------------------
// int2fp_seq : multi-cycle integer to IEEE-754 single-precision converter.
//
// One integer (signed or unsigned) is accepted through a valid/ready
// handshake, its magnitude is normalised by a one-bit-per-cycle left shifter,
// and the packed {sign, exponent, fraction} word is returned through a second
// valid/ready handshake. Default rounding is truncation toward zero.
//
// Optional build macro:
//   INT2FP_RNE_EN  - when defined, packing rounds to nearest, ties to even.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high, highest priority
//   in_valid   in   input integer valid
//   in_ready   out  converter can accept (high only while idle)
//   in_int     in   integer operand [IW-1:0]
//   in_signed  in   1 = in_int is two's complement, 0 = unsigned
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   result     out  IEEE-754 encoding [N-1:0]
//   inexact    out  nonzero bits were discarded below the fraction LSB
// ---------------------------------------------------------------------------
module int2fp_seq #(
    parameter int N  = 32,
    parameter int M  = 23,
    parameter int EB = N - M - 1,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_int,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  result,
    output logic          inexact
);

    // Shift counter must hold up to IW-1; it is also zero-extended into the
    // exponent, so it must not be wider than EB (true for IW <= 64).
    localparam int SW        = $clog2(IW) + 1;
    // Number of magnitude bits that fall below the fraction LSB.
    localparam int DW        = IW - 1 - M;
    // Exponent of a magnitude whose MSB sits at bit IW-1 with no shifting.
    localparam int EXP_TOP_I = 127 + IW - 1;

    localparam logic [EB-1:0] EXP_TOP = EXP_TOP_I[EB-1:0];
    localparam logic [SW-1:0] SH_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IW_ONE  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_NORM = 3'd2,
        S_PACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [IW-1:0]   int_r;
    logic            signed_r;
    logic            sign_r;
    logic [IW-1:0]   mag_r;
    logic [SW-1:0]   shcnt_r;
    logic [N-1:0]    result_r;
    logic            inexact_r;
    logic            in_ready_r;
    logic            out_valid_r;

    logic            abs_sign_s;
    logic [IW-1:0]   abs_mag_s;
    logic            norm_done_s;
    logic [M-1:0]    frac_s;
    logic [DW-1:0]   disc_s;
    logic [EB-1:0]   exp_s;
    logic [M-1:0]    frac_fin_s;
    logic [EB-1:0]   exp_fin_s;
    logic            inexact_s;
    logic [N-1:0]    pack_result_s;
`ifdef INT2FP_RNE_EN
    logic            rnd_bit_s;
    logic [DW-1:0]   sticky_bits_s;
    logic            sticky_s;
    logic [M:0]      frac_inc_s;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign inexact   = inexact_r;

    // Sign and magnitude of the captured operand; negating the most negative
    // value yields 2^(IW-1), which is exactly the wanted unsigned magnitude.
    always_comb begin
        abs_sign_s = signed_r & int_r[IW-1];
        if (abs_sign_s) begin
            abs_mag_s = ~int_r + IW_ONE;
        end else begin
            abs_mag_s = int_r;
        end
    end

    // Normalisation stops once the MSB is set or the magnitude is zero.
    always_comb begin
        norm_done_s = (mag_r == {IW{1'b0}}) || mag_r[IW-1];
    end

    // Packing: exponent from shift count, fraction below the hidden bit,
    // optional round-to-nearest-even with fraction carry into the exponent.
    always_comb begin
        frac_s = mag_r[IW-2 -: M];
        disc_s = mag_r[DW-1:0];
        exp_s  = EXP_TOP - {{(EB-SW){1'b0}}, shcnt_r};
`ifdef INT2FP_RNE_EN
        rnd_bit_s     = disc_s[DW-1];
        sticky_bits_s = disc_s << 1'b1;
        sticky_s      = |sticky_bits_s;
        frac_inc_s    = {1'b0, frac_s} + {{M{1'b0}}, 1'b1};
        if (rnd_bit_s && (sticky_s || frac_s[0])) begin
            frac_fin_s = frac_inc_s[M-1:0];
            exp_fin_s  = exp_s + {{(EB-1){1'b0}}, frac_inc_s[M]};
        end else begin
            frac_fin_s = frac_s;
            exp_fin_s  = exp_s;
        end
        inexact_s = rnd_bit_s | sticky_s;
`else
        frac_fin_s = frac_s;
        exp_fin_s  = exp_s;
        inexact_s  = |disc_s;
`endif
        if (mag_r == {IW{1'b0}}) begin
            pack_result_s = {N{1'b0}};
        end else begin
            pack_result_s = {sign_r, exp_fin_s, frac_fin_s};
        end
    end

    // Next-state logic of the conversion sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = S_ABS;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ABS: begin
                state_n = S_NORM;
            end
            S_NORM: begin
                if (norm_done_s) begin
                    state_n = S_PACK;
                end else begin
                    state_n = S_NORM;
                end
            end
            S_PACK: begin
                state_n = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DONE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register, registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {N{1'b0}};
            inexact_r   <= 1'b0;
            shcnt_r     <= {SW{1'b0}};
            int_r       <= {IW{1'b0}};
            signed_r    <= 1'b0;
            sign_r      <= 1'b0;
            mag_r       <= {IW{1'b0}};
        end else begin
            state_r     <= state_n;
            in_ready_r  <= (state_n == S_IDLE);
            out_valid_r <= (state_n == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        int_r    <= in_int;
                        signed_r <= in_signed;
                    end
                end
                S_ABS: begin
                    sign_r  <= abs_sign_s;
                    mag_r   <= abs_mag_s;
                    shcnt_r <= {SW{1'b0}};
                end
                S_NORM: begin
                    if (!norm_done_s) begin
                        mag_r   <= mag_r << 1'b1;
                        shcnt_r <= shcnt_r + SH_ONE;
                    end
                end
                S_PACK: begin
                    result_r  <= pack_result_s;
                    inexact_r <= inexact_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
